// File: rtl/benes_net_module.sv
// 8x8 Benes permutation network for 4-bit words: five stages of 2x2 switches,
// purely combinational routing followed by a single output register.
module benes_net_module (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_port     [8],
  input  logic [3:0] switch_set [5],
  output logic [3:0] o_port     [8]
);

  // Destination line after the wiring that follows stage s, for source line j.
  // The 4-line shuffle and unshuffle on a 2-bit local index are the same bit swap.
  function automatic logic [2:0] f_dest(input logic [2:0] s, input logic [2:0] j);
    case (s)
      3'd0:       f_dest = {j[0], j[2:1]};
      3'd1, 3'd2: f_dest = {j[2], j[0], j[1]};
      default:    f_dest = {j[1:0], j[2]};
    endcase
  endfunction

  logic [3:0] w_route [8];
  logic [3:0] r_port  [8];

  always_comb begin
    logic [3:0] v [8];
    logic [3:0] t [8];
    for (int j = 0; j < 8; j++) begin
      v[j]       = i_port[j];
      t[j]       = 4'h0;
      w_route[j] = 4'h0;
    end
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 4; k++) begin
        t[2*k]   = switch_set[s][k] ? v[2*k+1] : v[2*k];
        t[2*k+1] = switch_set[s][k] ? v[2*k]   : v[2*k+1];
      end
      for (int j = 0; j < 8; j++) begin
        if (s < 4) v[f_dest(3'(s), 3'(j))] = t[j];
        else       v[j] = t[j];
      end
    end
    for (int j = 0; j < 8; j++) begin
      w_route[j] = v[j];
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_out
    always_ff @(posedge clk) begin
      if (rst) r_port[gi] <= 4'h0;
      else     r_port[gi] <= w_route[gi];
    end
    assign o_port[gi] = r_port[gi];
  end

endmodule

// File: tb/tb_benes_net_module.sv
// Directed and random checks of the 8x8 Benes network against hand-computed
// vectors and an index-arithmetic model of the inter-stage wiring.
module tb_benes_net_module;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_port     [8];
  logic [3:0] switch_set [5];
  logic [3:0] o_port     [8];

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [31:0] IDN = 32'h76543210;

  benes_net_module dut (
    .clk        (clk),
    .rst        (rst),
    .i_port     (i_port),
    .switch_set (switch_set),
    .o_port     (o_port)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] ip, input logic [19:0] sw);
    for (int i = 0; i < 8; i++) i_port[i] = ip[4*i +: 4];
    for (int s = 0; s < 5; s++) switch_set[s] = sw[4*s +: 4];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] packed_out();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = o_port[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = packed_out();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Line-tracking model written directly from the k/b/h wiring formulas.
  function automatic logic [31:0] model(input logic [31:0] ip, input logic [19:0] sw);
    int line [8];
    int nl   [8];
    int dst, h, l, k, b, tmp;
    logic [31:0] r;
    for (int j = 0; j < 8; j++) line[j] = int'(ip[4*j +: 4]);
    for (int s = 0; s < 5; s++) begin
      for (int q = 0; q < 4; q++) begin
        if (sw[4*s + q]) begin
          tmp = line[2*q]; line[2*q] = line[2*q+1]; line[2*q+1] = tmp;
        end
      end
      if (s < 4) begin
        for (int j = 0; j < 8; j++) begin
          h = j / 4; l = j % 4;
          case (s)
            0: begin k = j / 2; b = j % 2; dst = 4*b + k; end
            1: begin k = l / 2; b = l % 2; dst = 4*h + 2*b + k; end
            2: begin b = l / 2; k = l % 2; dst = 4*h + 2*k + b; end
            default: begin b = j / 4; k = j % 4; dst = 2*k + b; end
          endcase
          nl[dst] = line[j];
        end
        for (int j = 0; j < 8; j++) line[j] = nl[j];
      end
    end
    for (int j = 0; j < 8; j++) r[4*j +: 4] = 4'(line[j]);
    return r;
  endfunction

  initial begin
    logic [31:0] ip;
    logic [19:0] sw;
    logic [2:0]  x;
    logic [7:0]  seen;
    logic [31:0] obs;

    rst = 1'b1;
    drive(IDN, 20'hA5C3F);
    tick(); check("reset_cycle1", 32'h0);
    tick(); check("reset_cycle2", 32'h0);

    rst = 1'b0;
    drive(IDN, 20'h00000);
    tick(); check("post_reset_identity", IDN);
    tick(); check("all_bar_hold", IDN);

    drive(IDN, 20'h0000F); tick(); check("stage0_cross", 32'h67452301);
    drive(IDN, 20'hF0000); tick(); check("stage4_cross", 32'h67452301);
    drive(IDN, 20'hF000F); tick(); check("stage0_4_cross", IDN);
    drive(IDN, 20'h00F00); tick(); check("stage2_cross", 32'h32107654);
    drive(IDN, 20'h00101); tick(); check("sw0_sw2_bit0", 32'h76513204);

    drive(32'h01234567, 20'h00000);
    tick(); check("reverse_input", 32'h01234567);
    tick(); check("reverse_hold", 32'h01234567);

    drive(IDN, 20'h00F00); tick(); check("alt_half_swap", 32'h32107654);
    drive(IDN, 20'h0000F); tick(); check("alt_pair_swap", 32'h67452301);
    drive(IDN, 20'h00F00); tick(); check("alt_half_swap2", 32'h32107654);

    rst = 1'b1; tick(); check("mid_reset", 32'h0);
    rst = 1'b0; tick(); check("resume_after_reset", 32'h32107654);

    for (int n = 0; n < 24; n++) begin
      sw = 20'($urandom);
      x  = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) ip[4*i +: 4] = {1'b0, 3'(i) ^ x};
      drive(ip, sw);
      tick();
      check($sformatf("random_%0d", n), model(ip, sw));
      obs  = packed_out();
      seen = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (obs[4*i+3] == 1'b0) seen[obs[4*i +: 3]] = 1'b1;
      end
      vectors++;
      assert (seen === 8'hFF) else begin
        miscompares++;
        $error("FAIL perm_%0d: observed set %b expected %b", n, seen, 8'hFF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
